// File: rtl/ray_pkg.sv
// Shared types and default widths for the ray/sphere setup stage.
package ray_pkg;

    localparam int COORD_W = 12;
    localparam int ROOT_W  = 32;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vec3_t;

    typedef enum logic [2:0] {IDLE, OFFSET, PRODUCT, DISC, SQRT, DONE} disc_state_e;

endpackage

// File: rtl/int_sqrt_iter.sv
// Restoring digit-by-digit floor square root, one result bit per clock.
module int_sqrt_iter #(
    parameter int ROOT_W = 32
) (
    input  logic                  CLK,
    input  logic                  areset,
    input  logic                  Start,
    input  logic [2*ROOT_W-1:0]   Radicand,
    output logic                  Done,
    output logic [ROOT_W-1:0]     Root
);

    localparam int CW = $clog2(ROOT_W + 1);
    localparam int RW = ROOT_W + 2;

    logic [RW-1:0]     rem_q, rem_cur, rem_sh, rem_nx, trial;
    logic [ROOT_W-1:0] root_q, root_cur, root_nx;
    logic [CW-1:0]     idx_q, idx_cur;
    logic [1:0]        pair;
    logic              busy_q, ge;

    // Start performs the first iteration directly from Radicand; the caller
    // must then hold Radicand stable until Done.
    always_comb begin
        rem_cur  = Start ? '0 : rem_q;
        root_cur = Start ? '0 : root_q;
        idx_cur  = Start ? '0 : idx_q;
        pair     = 2'(Radicand >> (2 * (ROOT_W - 1 - int'(idx_cur))));
        rem_sh   = (rem_cur << 2) | RW'(pair);
        trial    = {root_cur, 2'b01};
        ge       = (rem_sh >= trial);
        rem_nx   = ge ? (rem_sh - trial) : rem_sh;
        root_nx  = (root_cur << 1) | ROOT_W'(ge);
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            rem_q  <= '0;
            root_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Start) begin
                rem_q  <= rem_nx;
                root_q <= root_nx;
                idx_q  <= CW'(1);
                busy_q <= (ROOT_W > 1);
                Done   <= (ROOT_W == 1);
            end else if (busy_q) begin
                rem_q  <= rem_nx;
                root_q <= root_nx;
                idx_q  <= idx_q + CW'(1);
                if (idx_q == CW'(ROOT_W - 1)) begin
                    busy_q <= 1'b0;
                    Done   <= 1'b1;
                end
            end
        end
    end

    assign Root = root_q;

endmodule

// File: rtl/sphere_discriminant.sv
// Ray/sphere quadratic setup: computes B, disc = B^2 - 4AC and floor(sqrt(disc)).
module sphere_discriminant #(
    parameter int COORD_W = ray_pkg::COORD_W,
    parameter int ROOT_W  = ray_pkg::ROOT_W
) (
    input  logic                        CLK,
    input  logic                        areset,
    input  logic                        InputValid,
    output logic                        InputReady,
    input  logic [3*COORD_W-1:0]        RayOrigin,
    input  logic [3*COORD_W-1:0]        RayDir,
    input  logic [3*COORD_W-1:0]        SphereCenter,
    input  logic signed [COORD_W-1:0]   SphereRadius,
    output logic                        OutputValid,
    input  logic                        OutputAccept,
    output logic signed [31:0]          B,
    output logic [ROOT_W-1:0]           RootDiscriminant,
    output logic                        QuickIntersects
);

    import ray_pkg::*;

    localparam int W2 = 2 * ROOT_W;
    localparam int OW = COORD_W + 1;

    if (COORD_W > 12) begin : g_coord_chk
        $error("sphere_discriminant: COORD_W must not exceed 12");
    end
    if (ROOT_W < 16) begin : g_root_chk
        $error("sphere_discriminant: ROOT_W must be at least 16");
    end

    disc_state_e state, state_nx;

    logic signed [COORD_W-1:0] o_q [3];
    logic signed [COORD_W-1:0] d_q [3];
    logic signed [COORD_W-1:0] c_q [3];
    logic signed [COORD_W-1:0] r_q;
    logic signed [OW-1:0]      oc_q [3];
    logic signed [W2-1:0]      a_q, b_q, cc_q, disc_q;
    logic signed [W2-1:0]      a_c, b_c, cc_c, disc_c;
    logic [ROOT_W-1:0]         root_q, sq_root;
    logic [W2-1:0]             sq_rad;
    logic                      qi_q, in_fire, sq_start, sq_done;

    assign InputReady       = (state == IDLE);
    assign OutputValid      = (state == DONE);
    assign in_fire          = InputValid && InputReady;
    assign B                = b_q[31:0];
    assign RootDiscriminant = root_q;
    assign QuickIntersects  = qi_q;

    always_comb begin
        a_c  = '0;
        b_c  = '0;
        cc_c = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            a_c  = a_c  + W2'(d_q[k])  * W2'(d_q[k]);
            b_c  = b_c  + W2'(d_q[k])  * W2'(oc_q[k]);
            cc_c = cc_c + W2'(oc_q[k]) * W2'(oc_q[k]);
        end
        b_c    = b_c <<< 1;
        cc_c   = cc_c - W2'(r_q) * W2'(r_q);
        disc_c = b_q * b_q - ((a_q * cc_q) <<< 2);
    end

    // The root unit's first iteration happens on the DISC edge, so it sees
    // disc before it is registered; later iterations read the held copy.
    assign sq_rad = (state == DISC) ? disc_c : disc_q;

    always_comb begin
        state_nx = state;
        sq_start = 1'b0;
        case (state)
            IDLE:    if (in_fire) state_nx = OFFSET;
            OFFSET:  state_nx = PRODUCT;
            PRODUCT: state_nx = DISC;
            DISC: begin
                if (disc_c[W2-1]) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SQRT;
                    sq_start = 1'b1;
                end
            end
            SQRT:    if (sq_done) state_nx = DONE;
            DONE:    if (OutputAccept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            for (int unsigned k = 0; k < 3; k++) begin
                o_q[k]  <= '0;
                d_q[k]  <= '0;
                c_q[k]  <= '0;
                oc_q[k] <= '0;
            end
            r_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cc_q   <= '0;
            disc_q <= '0;
            root_q <= '0;
            qi_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        for (int unsigned k = 0; k < 3; k++) begin
                            o_q[k] <= RayOrigin[(2-k)*COORD_W +: COORD_W];
                            d_q[k] <= RayDir[(2-k)*COORD_W +: COORD_W];
                            c_q[k] <= SphereCenter[(2-k)*COORD_W +: COORD_W];
                        end
                        r_q <= SphereRadius;
                    end
                end
                OFFSET: begin
                    for (int unsigned k = 0; k < 3; k++)
                        oc_q[k] <= OW'(o_q[k]) - OW'(c_q[k]);
                end
                PRODUCT: begin
                    a_q  <= a_c;
                    b_q  <= b_c;
                    cc_q <= cc_c;
                end
                DISC: begin
                    disc_q <= disc_c;
                    qi_q   <= ~disc_c[W2-1];
                    root_q <= '0;
                end
                SQRT: begin
                    if (sq_done) root_q <= sq_root;
                end
                default: ;
            endcase
        end
    end

    int_sqrt_iter #(.ROOT_W(ROOT_W)) u_sqrt (
        .CLK      (CLK),
        .areset   (areset),
        .Start    (sq_start),
        .Radicand (sq_rad),
        .Done     (sq_done),
        .Root     (sq_root)
    );

endmodule

// File: tb/tb_sphere_discriminant.sv
// Directed bench for sphere_discriminant with hand-computed expected results.
module tb_sphere_discriminant;

    import ray_pkg::*;

    logic                      CLK = 1'b0;
    logic                      areset;
    logic                      InputValid;
    logic                      InputReady;
    vec3_t                     RayOrigin, RayDir, SphereCenter;
    logic signed [COORD_W-1:0] SphereRadius;
    logic                      OutputValid;
    logic                      OutputAccept;
    logic signed [31:0]        B;
    logic [ROOT_W-1:0]         RootDiscriminant;
    logic                      QuickIntersects;

    int checks = 0;
    int errors = 0;

    sphere_discriminant #(.COORD_W(COORD_W), .ROOT_W(ROOT_W)) dut (
        .CLK              (CLK),
        .areset           (areset),
        .InputValid       (InputValid),
        .InputReady       (InputReady),
        .RayOrigin        (RayOrigin),
        .RayDir           (RayDir),
        .SphereCenter     (SphereCenter),
        .SphereRadius     (SphereRadius),
        .OutputValid      (OutputValid),
        .OutputAccept     (OutputAccept),
        .B                (B),
        .RootDiscriminant (RootDiscriminant),
        .QuickIntersects  (QuickIntersects)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_txn(input int ox, input int oy, input int oz,
                           input int dx, input int dy, input int dz,
                           input int cx, input int cy, input int cz, input int r);
        RayOrigin.x    = COORD_W'(ox);
        RayOrigin.y    = COORD_W'(oy);
        RayOrigin.z    = COORD_W'(oz);
        RayDir.x       = COORD_W'(dx);
        RayDir.y       = COORD_W'(dy);
        RayDir.z       = COORD_W'(dz);
        SphereCenter.x = COORD_W'(cx);
        SphereCenter.y = COORD_W'(cy);
        SphereCenter.z = COORD_W'(cz);
        SphereRadius   = COORD_W'(r);
    endtask

    // Entered and left at posedge+1.
    task automatic run_txn(input string tag, input int exp_b, input int exp_root,
                           input int exp_qi, input int exp_lat, input bit hold);
        int lat;
        OutputAccept = hold;
        InputValid   = 1'b1;
        chk({tag, ".in_ready"}, 64'(InputReady), 1);
        @(posedge CLK); #1;
        InputValid = 1'b0;
        lat = 0;
        while (!OutputValid && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".B"}, B, exp_b);
        chk({tag, ".root"}, 64'(RootDiscriminant), exp_root);
        chk({tag, ".qi"}, 64'(QuickIntersects), exp_qi);
        OutputAccept = 1'b1;
        @(posedge CLK); #1;
        chk({tag, ".ready_after"}, 64'(InputReady), 1);
        chk({tag, ".valid_after"}, 64'(OutputValid), 0);
        OutputAccept = 1'b0;
    endtask

    initial begin
        int lat;
        areset       = 1'b1;
        InputValid   = 1'b0;
        OutputAccept = 1'b0;
        set_txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.in_ready", 64'(InputReady), 1);
        chk("rst.valid", 64'(OutputValid), 0);
        chk("rst.B", B, 0);
        chk("rst.root", 64'(RootDiscriminant), 0);
        chk("rst.qi", 64'(QuickIntersects), 0);
        areset = 1'b0;
        @(posedge CLK); #1;

        set_txn(0, 0, -10,  0, 0, 1,  0, 0, 0,  2);
        run_txn("hit", -20, 4, 1, 35, 1'b0);
        set_txn(0, 10, 0,  0, -1, 0,  10, -10, 10,  2);
        run_txn("miss", -40, 0, 0, 3, 1'b0);
        set_txn(0, 0, 0,  1, 1, 0,  10, 10, 0,  3);
        run_txn("disc72", -40, 8, 1, 35, 1'b0);
        set_txn(0, 2, -10,  0, 0, 1,  0, 0, 0,  2);
        run_txn("tangent", -20, 0, 1, 35, 1'b0);
        set_txn(5, 5, 5,  0, 0, 0,  0, 0, 0,  1);
        run_txn("d_zero", 0, 0, 1, 35, 1'b0);
        set_txn(0, 0, 0,  1, 2, 3,  1, 1, 1,  10);
        run_txn("disc5576", -12, 74, 1, 35, 1'b0);
        set_txn(-2048, -2048, -2048,  2047, 2047, 2047,  2047, 2047, 2047,  1);
        run_txn("extreme", -50294790, 7091, 1, 35, 1'b0);
        set_txn(0, 10, 0,  0, -1, 0,  10, -10, 10,  2);
        run_txn("accept_early", -40, 0, 0, 3, 1'b1);

        // Backpressure: result held while a second request is refused.
        set_txn(0, 0, -10,  0, 0, 1,  0, 0, 0,  2);
        InputValid = 1'b1;
        @(posedge CLK); #1;
        InputValid = 1'b0;
        lat = 0;
        while (!OutputValid && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("bp.latency", lat, 35);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                set_txn(0, 10, 0,  0, -1, 0,  10, -10, 10,  2);
                InputValid = 1'b1;
            end
            if (i == 6) InputValid = 1'b0;
            @(posedge CLK); #1;
            chk("bp.valid", 64'(OutputValid), 1);
            chk("bp.in_ready", 64'(InputReady), 0);
            chk("bp.B", B, -20);
            chk("bp.root", 64'(RootDiscriminant), 4);
            chk("bp.qi", 64'(QuickIntersects), 1);
        end
        OutputAccept = 1'b1;
        @(posedge CLK); #1;
        OutputAccept = 1'b0;
        chk("bp.release_ready", 64'(InputReady), 1);
        chk("bp.release_valid", 64'(OutputValid), 0);
        repeat (6) @(posedge CLK);
        #1;
        chk("bp.no_ghost_valid", 64'(OutputValid), 0);
        chk("bp.no_ghost_ready", 64'(InputReady), 1);

        // Reset while the root unit is iterating.
        set_txn(0, 0, -10,  0, 0, 1,  0, 0, 0,  2);
        InputValid = 1'b1;
        @(posedge CLK); #1;
        InputValid = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        chk("midrst.busy_ready", 64'(InputReady), 0);
        areset = 1'b1;
        #1;
        chk("midrst.valid", 64'(OutputValid), 0);
        chk("midrst.in_ready", 64'(InputReady), 1);
        chk("midrst.qi", 64'(QuickIntersects), 0);
        chk("midrst.B", B, 0);
        @(posedge CLK); #1;
        areset = 1'b0;
        @(posedge CLK); #1;
        set_txn(0, 0, 0,  1, 1, 0,  10, 10, 0,  3);
        run_txn("after_rst", -40, 8, 1, 35, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sphere_discriminant.md
Name: sphere_discriminant

Overview:
- Ray/sphere setup stage directly upstream of DistanceCalculator.
- Accepts one ray origin, ray direction, sphere centre and radius per transaction.
- Computes the quadratic terms A = |d|^2, B = 2·d·(o−c), C = |o−c|^2 − r^2 and disc = B^2 − 4AC.
- Produces floor(sqrt(disc)) with an iterative root unit, and presents B, RootDiscriminant and QuickIntersects on a valid/ready output port wired to DistanceCalculator's InputValid/InputReady.

Parameters:
- COORD_W, 12: signed width of every coordinate and the radius.
- ROOT_W, 32: width of RootDiscriminant. The sqrt runs ROOT_W iterations; disc is held in 2·ROOT_W bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- InputValid  in  1  upstream presents a valid ray/sphere pair.
- InputReady  out  1  block can accept a transaction.
- RayOrigin  in  3×COORD_W signed  {x,y,z}.
- RayDir  in  3×COORD_W signed  {x,y,z}.
- SphereCenter  in  3×COORD_W signed  {x,y,z}.
- SphereRadius  in  COORD_W signed  radius; must be non-negative.
- OutputValid  out  1  result valid, held until accepted.
- OutputAccept  in  1  downstream ready (DistanceCalculator InputReady).
- B  out  32 signed  2·d·(o−c).
- RootDiscriminant  out  ROOT_W  floor(sqrt(disc)); 0 when disc < 0.
- QuickIntersects  out  1  1 iff disc ≥ 0.

Behaviour:
- Reset (async, while areset = 1):
  - State = IDLE; InputReady = 1; OutputValid = 0.
  - B, RootDiscriminant, QuickIntersects = 0; all internal registers = 0.
  - Assertion mid-transaction discards that transaction.
  - After deassertion the block is in IDLE with InputReady = 1 at the first edge.
- Handshake:
  - Input transfer occurs on an edge where InputValid && InputReady. All inputs are captured at that edge.
  - InputReady = 1 only in IDLE. There is one transaction in flight; no overlap.
  - Output transfer occurs on an edge where OutputValid && OutputAccept.
  - B, RootDiscriminant and QuickIntersects are stable for as long as OutputValid = 1.
- States:
  - IDLE: on input handshake → OFFSET.
  - OFFSET: register oc = o − c per axis (COORD_W+1 bits) and d → PRODUCT.
  - PRODUCT: register A = Σd², B = 2·Σd·oc, C = Σoc² − r² (all sign-extended to 2·ROOT_W) → DISC.
  - DISC: register disc = B² − 4·A·C (2·ROOT_W signed).
    - disc < 0 → DONE with QuickIntersects = 0 and RootDiscriminant = 0.
    - disc ≥ 0 → SQRT with the root unit started and QuickIntersects = 1.
  - SQRT: one restoring digit-by-digit iteration per cycle, ROOT_W iterations → DONE.
  - DONE: OutputValid = 1. On output handshake → IDLE.
- Latency, counted from the input-handshake edge E0:
  - OutputValid rises after E3 when disc < 0.
  - OutputValid rises after E3+ROOT_W (E35 at default) when disc ≥ 0.
  - Output handshake at edge Ek gives InputReady = 1 after Ek. Minimum back-to-back period is latency + 1 cycles.
- Arithmetic:
  - All products are signed full-width with no saturation.
  - With COORD_W = 12, B fits 29 bits and is sign-extended into 32.
  - disc fits 2·ROOT_W; overflow is impossible for COORD_W ≤ 12.
  - The parameter rule COORD_W ≤ 12 is checked by elaboration-time $error.
- Root unit: floor sqrt, exact for perfect squares, result never exceeds the true root.
  - disc = 0 → root 0 and QuickIntersects = 1 (tangent ray).
- Boundary conditions:
  - d = 0: A = 0, B = 0, disc = 0, QuickIntersects = 1, RootDiscriminant = 0. Downstream must treat this as degenerate.
  - OutputAccept held high while OutputValid = 0 has no effect.
  - InputValid while not ready is ignored, and inputs are not sampled.

Decomposition:
- ray_pkg holds:
  - the COORD_W default;
  - typedef vec3_t (packed struct x,y,z of signed [COORD_W-1:0]);
  - typedef disc_state_e {IDLE, OFFSET, PRODUCT, DISC, SQRT, DONE};
  - ROOT_W default.
- Sub-module int_sqrt_iter (ROOT_W parameter):
  - ports CLK, areset, Start, Radicand[2·ROOT_W-1:0], Done, Root[ROOT_W-1:0];
  - contains its own iteration counter;
  - Done is a one-cycle pulse after ROOT_W cycles.

Test Plan:
- o=(0,0,−10), d=(0,0,1), c=(0,0,0), r=2 → B=−20, RootDiscriminant=4, QuickIntersects=1; OutputValid rises 35 cycles after the input handshake.
- o=(0,10,0), d=(0,−1,0), c=(10,−10,10), r=2 → disc=−784, B=−40, RootDiscriminant=0, QuickIntersects=0; OutputValid rises 3 cycles after the input handshake.
- o=(0,0,0), d=(1,1,0), c=(10,10,0), r=3 → disc=72, B=−40, RootDiscriminant=8, QuickIntersects=1.
- Tangent case o=(0,2,−10), d=(0,0,1), c=(0,0,0), r=2 → disc=0, B=−20, RootDiscriminant=0, QuickIntersects=1.
- Backpressure and chaining:
  - Hold OutputAccept=0 for 10 cycles after OutputValid → outputs stable, InputReady=0, a second InputValid is ignored.
  - Release OutputAccept → InputReady=1 the next cycle.
  - Connect to DistanceCalculator with OldDistance=1000 for case 1 → Distance=8.
- Assert areset during SQRT of case 1 → OutputValid=0 and InputReady=1 immediately; a fresh case-3 transaction then completes correctly.
